// File: rtl/mem_resp_pipe_4c_pkg.sv
// Shared types and helpers for the memory-side fill responder.
// Optional feature macro: MEM_RESP_WR_ACK_EN (write acknowledge pulses).
package mem_pkg;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned MEM_ADDR_W = 16;
    localparam int unsigned OUTS_W     = 4;

    typedef struct packed {
        logic                  enable;
        logic                  wr;
        logic [MEM_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
    } mem_req_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
    } mem_rsp_t;

    // Byte address to word index; the caller keeps only the bits it needs.
    function automatic logic [MEM_ADDR_W-1:0] word_idx(input logic [MEM_ADDR_W-1:0] addr);
        return {1'b0, addr[MEM_ADDR_W-1:1]};
    endfunction
endpackage

// File: rtl/mem_resp_pipe_4c_if.sv
// Request/response bus between a fill engine (master) and the responder (slave).
// Optional feature macro: MEM_RESP_WR_ACK_EN adds wr_ack.
interface mem_resp_pipe_4c_if;
    import mem_pkg::*;

    logic                  enable;
    logic                  wr;
    logic [MEM_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     data_in;
    logic [WORD_W-1:0]     data_out;
    logic                  data_valid;
    logic                  busy;
    logic [OUTS_W-1:0]     outstanding;
`ifdef MEM_RESP_WR_ACK_EN
    logic                  wr_ack;
`endif

    modport master (
        output enable, wr, addr, data_in,
`ifdef MEM_RESP_WR_ACK_EN
        input  wr_ack,
`endif
        input  data_out, data_valid, busy, outstanding
    );

    modport slave (
        input  enable, wr, addr, data_in,
`ifdef MEM_RESP_WR_ACK_EN
        output wr_ack,
`endif
        output data_out, data_valid, busy, outstanding
    );
endinterface

// File: rtl/mem_resp_pipe_4c_delay.sv
// mem_rsp_delay: DEPTH-deep valid/payload shift register with async clear.
// Payload only advances alongside a valid bit, so the last stage keeps its
// most recent emitted value through bubbles.
module mem_rsp_delay #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o
);
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];

    // Next-state: shift valid every cycle, move payload only with a valid bit.
    always_comb begin
        valid_d[0] = in_valid_i;
        data_d[0]  = in_valid_i ? in_data_i : data_q[0];
        for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    // Stage registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];
endmodule

// File: rtl/mem_resp_pipe_4c.sv
// mem_resp_pipe_4c: word-addressed storage answering fill requests with a
// fixed LATENCY, fully pipelined. Optional macro MEM_RESP_WR_ACK_EN sends
// writes through the pipeline as well and pulses wr_ack for them.
module mem_resp_pipe_4c
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned WORD_W  = mem_pkg::WORD_W
) (
    input  logic               clk,
    input  logic               rst,
    mem_resp_pipe_4c_if.slave  bus
);
`ifdef MEM_RESP_WR_ACK_EN
    localparam int unsigned PW = WORD_W + 1;
`else
    localparam int unsigned PW = WORD_W;
`endif

    logic [WORD_W-1:0] mem_q [2**ADDR_W];
    mem_req_t          req;
    mem_rsp_t          rsp;
    logic [ADDR_W-1:0] idx;
    logic              track;
    logic [PW-1:0]     pay_in, pay_out;
    logic              out_valid;
    logic [OUTS_W-1:0] outstanding_q, outstanding_d;

    // Request decode and pipeline entry.
    always_comb begin
        req.enable = bus.enable;
        req.wr     = bus.wr;
        req.addr   = bus.addr;
        req.data   = bus.data_in;
        idx        = ADDR_W'(word_idx(req.addr));
`ifdef MEM_RESP_WR_ACK_EN
        track      = req.enable;
        pay_in     = {req.wr, mem_q[idx]};
`else
        track      = req.enable & ~req.wr;
        pay_in     = mem_q[idx];
`endif
    end

    // Writes commit at the sampling edge; storage is never cleared.
    always_ff @(posedge clk) begin
        if (req.enable && req.wr) mem_q[idx] <= req.data;
    end

    mem_rsp_delay #(
        .DEPTH (LATENCY),
        .W     (PW)
    ) u_delay (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (track),
        .in_data_i   (pay_in),
        .out_valid_o (out_valid),
        .out_data_o  (pay_out)
    );

    // Response decode from the final pipeline stage.
    always_comb begin
`ifdef MEM_RESP_WR_ACK_EN
        rsp.valid  = out_valid & ~pay_out[PW-1];
        rsp.data   = pay_out[WORD_W-1:0];
        bus.wr_ack = out_valid & pay_out[PW-1];
`else
        rsp.valid  = out_valid;
        rsp.data   = pay_out;
`endif
        outstanding_d = outstanding_q + OUTS_W'(track) - OUTS_W'(out_valid);
    end

    // In-flight counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) outstanding_q <= '0;
        else     outstanding_q <= outstanding_d;
    end

    assign bus.data_valid  = rsp.valid;
    assign bus.data_out    = rsp.data;
    assign bus.outstanding = outstanding_q;
    assign bus.busy        = (outstanding_q != '0);
endmodule

// File: tb/tb_mem_resp_pipe_4c.sv
// Self-checking bench for mem_resp_pipe_4c against a cycle-indexed request
// history model.
module tb_mem_resp_pipe_4c;
    localparam int LAT  = 4;
    localparam int AW   = 10;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_resp_pipe_4c_if bus ();

    mem_resp_pipe_4c #(
        .LATENCY (LAT),
        .ADDR_W  (AW),
        .WORD_W  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int kill_from = 0;
    int pulses = 0;
    int peak = 0;
    string tag = "init";

    bit          rq_rd [MAXC];
    bit          rq_wr [MAXC];
    logic [15:0] rq_dat [MAXC];
    logic [15:0] mem_m [2**AW];
    logic [15:0] seen_q [$];
    int          seen_c [$];

    // One bus cycle: record the request in the model, advance, compare outputs.
    task automatic drive_cycle(input bit en, input bit w, input logic [15:0] a, input logic [15:0] d);
        int idx;
        int lo;
        int exp_out;
        bit exp_dv;
        bit exp_ack;
        logic [15:0] exp_data;
        idx = int'(a[AW:1]);
        bus.enable = en; bus.wr = w; bus.addr = a; bus.data_in = d;
        rq_rd[cyc] = en && !w;
        rq_wr[cyc] = en && w;
        if (en && !w) rq_dat[cyc] = mem_m[idx];
        if (en && w) mem_m[idx] = d;
        @(posedge clk); #1;
        cyc++;
        bus.enable = 1'b0;
        exp_dv = 1'b0; exp_ack = 1'b0; exp_data = '0;
        if (cyc - LAT >= kill_from && cyc - LAT >= 0) begin
            exp_dv   = rq_rd[cyc-LAT];
            exp_ack  = rq_wr[cyc-LAT];
            exp_data = rq_dat[cyc-LAT];
        end
        lo = cyc - LAT;
        if (lo < kill_from) lo = kill_from;
        if (lo < 0) lo = 0;
        exp_out = 0;
        for (int t = lo; t < cyc; t++) begin
`ifdef MEM_RESP_WR_ACK_EN
            if (rq_rd[t] || rq_wr[t]) exp_out++;
`else
            if (rq_rd[t]) exp_out++;
`endif
        end
        checks++;
        if (bus.data_valid !== exp_dv) begin
            errors++;
            $display("FAIL %s cyc=%0d data_valid got %b exp %b", tag, cyc, bus.data_valid, exp_dv);
        end
        if (exp_dv) begin
            checks++;
            if (bus.data_out !== exp_data) begin
                errors++;
                $display("FAIL %s cyc=%0d data_out got %h exp %h", tag, cyc, bus.data_out, exp_data);
            end
        end
        checks++;
        if (bus.outstanding !== 4'(exp_out)) begin
            errors++;
            $display("FAIL %s cyc=%0d outstanding got %0d exp %0d", tag, cyc, bus.outstanding, exp_out);
        end
        checks++;
        if (bus.busy !== (exp_out != 0)) begin
            errors++;
            $display("FAIL %s cyc=%0d busy got %b exp %b", tag, cyc, bus.busy, exp_out != 0);
        end
`ifdef MEM_RESP_WR_ACK_EN
        checks++;
        if (bus.wr_ack !== exp_ack) begin
            errors++;
            $display("FAIL %s cyc=%0d wr_ack got %b exp %b", tag, cyc, bus.wr_ack, exp_ack);
        end
`endif
        if (bus.data_valid === 1'b1) begin
            pulses++;
            seen_q.push_back(bus.data_out);
            seen_c.push_back(cyc);
        end
        if (int'(bus.outstanding) > peak) peak = int'(bus.outstanding);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic clear_obs();
        pulses = 0; peak = 0;
        seen_q.delete(); seen_c.delete();
    endtask

    task automatic test_reset();
        tag = "reset";
        checks++;
        if (bus.data_valid !== 1'b0 || bus.outstanding !== 4'd0 || bus.busy !== 1'b0 || bus.data_out !== 16'h0) begin
            errors++;
            $display("FAIL %s dv=%b outst=%0d busy=%b dout=%h exp 0/0/0/0000", tag,
                     bus.data_valid, bus.outstanding, bus.busy, bus.data_out);
        end
    endtask

    task automatic test_preload();
        int t0;
        tag = "preload";
        clear_obs();
        t0 = cyc;
        drive_cycle(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        idle(1);
        drive_cycle(1'b1, 1'b0, 16'h0010, 16'h0);
        idle(LAT + 2);
        checks++;
        if (pulses != 1 || seen_c[0] - t0 != 2 + LAT || seen_q[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL %s pulses=%0d rel_cycle=%0d data=%h exp 1/%0d/beef", tag, pulses,
                     (pulses > 0) ? seen_c[0] - t0 : -1, (pulses > 0) ? seen_q[0] : 16'hxxxx, 2 + LAT);
        end
    endtask

    task automatic test_line_fill();
        tag = "line_fill";
        for (int unsigned i = 0; i < 8; i++)
            drive_cycle(1'b1, 1'b1, 16'(16'h0020 + 2*i), 16'(16'h1000 + i));
        clear_obs();
        for (int unsigned i = 0; i < 8; i++)
            drive_cycle(1'b1, 1'b0, 16'(16'h0020 + 2*i), 16'h0);
        idle(LAT + 1);
        checks++;
        if (pulses != 8 || peak != LAT) begin
            errors++;
            $display("FAIL %s pulses=%0d peak=%0d exp 8/%0d", tag, pulses, peak, LAT);
        end
        for (int i = 0; i < 8 && i < pulses; i++) begin
            checks++;
            if (seen_q[i] !== 16'(16'h1000 + i) || (i > 0 && seen_c[i] != seen_c[i-1] + 1)) begin
                errors++;
                $display("FAIL %s beat%0d data=%h cyc=%0d exp %h consecutive", tag, i, seen_q[i], seen_c[i], 16'(16'h1000 + i));
            end
        end
    endtask

    task automatic test_read_after_write();
        tag = "raw";
        drive_cycle(1'b1, 1'b1, 16'h0040, 16'h5555);
        clear_obs();
        drive_cycle(1'b1, 1'b0, 16'h0040, 16'h0);
        drive_cycle(1'b1, 1'b1, 16'h0040, 16'h1234);
        drive_cycle(1'b1, 1'b0, 16'h0041, 16'h0);
        idle(LAT + 1);
        checks++;
        if (pulses != 2 || seen_q[0] !== 16'h5555 || seen_q[1] !== 16'h1234) begin
            errors++;
            $display("FAIL %s pulses=%0d first=%h second=%h exp 2/5555/1234", tag, pulses,
                     (pulses > 0) ? seen_q[0] : 16'hxxxx, (pulses > 1) ? seen_q[1] : 16'hxxxx);
        end
    endtask

    task automatic test_reset_mid_burst();
        tag = "reset_burst";
        clear_obs();
        for (int unsigned i = 0; i < 4; i++)
            drive_cycle(1'b1, 1'b0, 16'(16'h0020 + 2*i), 16'h0);
        idle(1);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.data_valid !== 1'b0 || bus.outstanding !== 4'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s immediate dv=%b outst=%0d busy=%b exp 0/0/0", tag, bus.data_valid, bus.outstanding, bus.busy);
        end
        rq_rd[cyc] = 1'b0; rq_wr[cyc] = 1'b0;
        @(posedge clk); #1;
        cyc++;
        rst = 1'b0;
        kill_from = cyc;
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL %s pulses_before_reset got %0d exp 2", tag, pulses);
        end
        clear_obs();
        idle(LAT + 2);
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL %s pulses_after_reset got %0d exp 0", tag, pulses);
        end
        drive_cycle(1'b1, 1'b0, 16'h0026, 16'h0);
        idle(LAT + 1);
        checks++;
        if (pulses != 1 || seen_q[0] !== 16'h1003) begin
            errors++;
            $display("FAIL %s persist pulses=%0d data=%h exp 1/1003", tag, pulses, (pulses > 0) ? seen_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [9:0]  wi;
        tag = "random";
        for (int unsigned i = 0; i < 32; i++)
            drive_cycle(1'b1, 1'b1, 16'(16'h0200 + 2*i), 16'($urandom));
        // Top word written through one alias, read back through others below.
        drive_cycle(1'b1, 1'b1, 16'h07FE, 16'hA5C3);
        drive_cycle(1'b1, 1'b0, 16'hF7FF, 16'h0);
        for (int i = 0; i < 300; i++) begin
            wi = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'(10'h100 + $urandom_range(0, 31));
            a  = {5'($urandom), wi, 1'($urandom)};
            drive_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, a, 16'($urandom));
        end
        idle(LAT + 1);
    endtask

`ifdef MEM_RESP_WR_ACK_EN
    task automatic test_wr_ack();
        tag = "wr_ack";
        clear_obs();
        drive_cycle(1'b1, 1'b1, 16'h0060, 16'h7777);
        idle(LAT + 1);
        drive_cycle(1'b1, 1'b1, 16'h0062, 16'h1111);
        drive_cycle(1'b1, 1'b0, 16'h0060, 16'h0);
        drive_cycle(1'b1, 1'b1, 16'h0064, 16'h2222);
        idle(LAT + 1);
        checks++;
        if (pulses != 1 || seen_q[0] !== 16'h7777) begin
            errors++;
            $display("FAIL %s read pulses=%0d data=%h exp 1/7777", tag, pulses, (pulses > 0) ? seen_q[0] : 16'hxxxx);
        end
    endtask
`endif

    initial begin
        bus.enable = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        cyc = 0;
        kill_from = 0;
        idle(2);
        test_preload();
        test_line_fill();
        test_read_after_write();
        test_reset_mid_burst();
        test_random();
`ifdef MEM_RESP_WR_ACK_EN
        test_wr_ack();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_resp_pipe_4c.md
Name: mem_resp_pipe_4c

Overview:
- Memory-side responder for the cache fill protocol: the end that answers the fill engine's word requests (enable/addr in, data/data_valid out).
- Holds a word-addressed 16-bit storage array.
- Accepts one request per cycle and returns read data after a fixed, parameterised latency.
- Requests are fully pipelined, so an 8-word line fill can be issued back-to-back.
- Sits between the I/D cache fill engines (via arbiter) and the main memory model.

Parameters:
- LATENCY, 4, cycles from request to data_valid; legal range 1..15.
- ADDR_W, 10, word-index width; array depth is 2**ADDR_W words.
- WORD_W, 16, data width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  request strobe, sampled at rising edge.
- wr  input  1  1 = write request, 0 = read request; valid with enable.
- addr  input  16  byte address; word index = addr[ADDR_W:1]; addr[0] ignored; bits above ADDR_W ignored.
- data_in  input  16  write data; valid with enable & wr.
- data_out  output  16  read data; valid only while data_valid.
- data_valid  output  1  one-cycle pulse per read, LATENCY cycles after the request.
- busy  output  1  1 while any read is in flight.
- outstanding  output  4  number of reads in flight.

Behaviour:
- Reset (async, any time):
  - Clears pipeline valid bits, data_valid=0, data_out=0, outstanding=0, busy=0 immediately.
  - Storage array is NOT cleared; contents persist across reset and are undefined until written.
- Write:
  - enable & wr at edge N commits data_in to array[idx] at edge N.
  - No response pulse (see optional feature).
- Read:
  - enable & ~wr in cycle t snapshots array[idx] at the end of cycle t.
  - data_valid=1 and data_out=snapshot during cycle t+LATENCY only.
- Ordering and forwarding:
  - A read issued the cycle after a write to the same word returns the new data.
  - No forwarding into earlier in-flight reads; each read returns its snapshot.
- Pipelining:
  - One request accepted every cycle, no backpressure.
  - Responses come out in request order.
  - K back-to-back reads produce K consecutive data_valid cycles.
- Internal structure: LATENCY-stage shift register of {valid, data}; stage 0 is loaded on the sampled request; the final stage drives the outputs.
- outstanding:
  - Increments on an accepted read and decrements when the final stage emits.
  - Both in one cycle leaves it unchanged.
  - Never exceeds LATENCY.
- busy = (outstanding != 0).
- data_out holds its last value when data_valid=0; only the data_valid cycle is checked.
- X on enable is illegal; wr is don't-care when enable=0.
- Requests with enable=0 leave the array and pipeline unchanged (bubble shifts through).

Optional Feature:
- Macro MEM_RESP_WR_ACK_EN.
- Defined:
  - Adds output wr_ack (1 bit).
  - Writes also traverse the pipeline; wr_ack pulses in cycle t+LATENCY for a write issued in cycle t.
  - data_valid stays low for writes.
  - outstanding counts writes as well as reads.
  - Write commit timing to the array is unchanged.
- Undefined: no wr_ack port; behaviour exactly as above.

Decomposition:
- Package mem_pkg:
  - WORD_W=16, MEM_ADDR_W=16.
  - Typedef mem_req_t {enable, wr, addr, data}.
  - Typedef mem_rsp_t {valid, data}.
  - Function word_idx(addr).
- Sub-module mem_rsp_delay: a LATENCY-deep valid/data shift register with async active-high clear. It is instantiated once; the top holds the array, request decode and outstanding counter.

Test Plan:
- Preload: write 0xBEEF to addr 0x0010 at t=0; read addr 0x0010 at t=2 -> data_valid=1, data_out=0xBEEF in cycle 6 only; busy=1 in cycles 3-6.
- Line fill: write 0x1000+i to words 0x0020+2i (i=0..7), then 8 back-to-back reads of 0x0020..0x002E -> data_valid high 8 consecutive cycles, data 0x1000..0x1007 in order; outstanding peaks at 4.
- Read-after-write: write 0x1234 to 0x0040 in cycle t, read 0x0040 in cycle t+1 -> 0x1234 returned. Read 0x0040 in cycle t-1 -> old value returned.
- Reset mid-burst: issue 4 reads, assert rst for 1 cycle after the 2nd response -> data_valid=0, outstanding=0 immediately, no further pulses. Earlier written data is still readable afterwards.
- LATENCY=1 build: read in cycle t -> data_valid in t+1; alternating read/idle gives alternating pulses; outstanding never exceeds 1.
- MEM_RESP_WR_ACK_EN build: write at t -> wr_ack in t+4, data_valid stays 0; mixed W/R/W stream -> wr_ack/data_valid pattern 1,0 / 0,1 / 1,0.
